frame_pipe_sequencer: RTL and testbench

Per-frame controller that drives the MVP mesh pipelines (airplane, terrain, …) and the downstream rasterizer. On each frame tick it latches a coherent pose snapshot. It then broadcasts `update_mvp` to every mesh pipe, runs the pipes one at a time so that only one writes MVP output RAM at any moment, starts the rasterizer, and reports completion. It sits between the vsync/frame timer and the `pipe_*_mesh` instances.

---
 rtl/frame_pipe_sequencer.sv | 148 ++++++++++++++
 tb/tb_frame_pipe_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pipe_sequencer.sv
// frame_pipe_sequencer: latches a pose per frame, runs mesh pipes one at a time, then the rasterizer.
// Optional watchdog abort on stalled pipes is built only when FRAME_SEQ_WATCHDOG_EN is defined.
module frame_pipe_sequencer #(
   parameter int NUM_MESH = 2,
   parameter int TIMEOUT  = 65535
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic                pose_valid,
   input  logic [31:0]         roll_in,
   input  logic [31:0]         pitch_in,
   input  logic [31:0]         yaw_in,
   input  logic [31:0]         x_in,
   input  logic [31:0]         y_in,
   input  logic [31:0]         z_in,
   output logic [31:0]         roll,
   output logic [31:0]         pitch,
   output logic [31:0]         yaw,
   output logic [31:0]         x,
   output logic [31:0]         y,
   output logic [31:0]         z,
   output logic [NUM_MESH-1:0] mesh_update_mvp,
   output logic [NUM_MESH-1:0] mesh_start,
   input  logic [NUM_MESH-1:0] mesh_done,
   output logic                raster_start,
   input  logic                raster_done,
   output logic                busy,
   output logic                frame_done,
   output logic                frame_drop,
   output logic                error,
   output logic [15:0]         frame_count,
   output logic [7:0]          drop_count
);
   localparam int IW = NUM_MESH > 1 ? $clog2(NUM_MESH) : 1;
   localparam logic [2:0] S_IDLE = 3'd0, S_UPDATE = 3'd1, S_START = 3'd2, S_WAIT = 3'd3,
                          S_RGO = 3'd4, S_RWAIT = 3'd5, S_DONE = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [5:0][31:0] pose_q, pose_d;
   logic [15:0]      fc_q, fc_d;
   logic [7:0]       dc_q, dc_d;
   logic             drop, err_c;
`ifdef FRAME_SEQ_WATCHDOG_EN
   localparam logic [23:0] TO = 24'(TIMEOUT);
   logic [23:0]      wd_q, wd_d;
`endif

   assign drop = frame_tick && state_q != S_IDLE;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pose_d  = pose_q;
      fc_d    = fc_q;
      err_c   = 1'b0;
      dc_d    = (drop && dc_q != 8'hFF) ? dc_q + 8'd1 : dc_q;
`ifdef FRAME_SEQ_WATCHDOG_EN
      wd_d    = wd_q;
`endif
      case (state_q)
         S_IDLE: if (frame_tick) begin
            pose_d  = pose_valid ? {z_in, y_in, x_in, yaw_in, pitch_in, roll_in} : pose_q;
            idx_d   = '0;
            state_d = S_UPDATE;
         end
         S_UPDATE: state_d = S_START;
         S_START: begin
            state_d = S_WAIT;
`ifdef FRAME_SEQ_WATCHDOG_EN
            wd_d    = '0;
`endif
         end
         S_WAIT: if (mesh_done[idx_q]) begin
            state_d = (idx_q == IW'(NUM_MESH - 1)) ? S_RGO : S_START;
            idx_d   = (idx_q == IW'(NUM_MESH - 1)) ? idx_q : idx_q + IW'(1);
         end
`ifdef FRAME_SEQ_WATCHDOG_EN
         else if (wd_q == TO) begin
            err_c   = 1'b1;
            state_d = S_IDLE;
         end else wd_d = wd_q + 24'd1;
`endif
         S_RGO: begin
            state_d = S_RWAIT;
`ifdef FRAME_SEQ_WATCHDOG_EN
            wd_d    = '0;
`endif
         end
         S_RWAIT: if (raster_done) state_d = S_DONE;
`ifdef FRAME_SEQ_WATCHDOG_EN
         else if (wd_q == TO) begin
            err_c   = 1'b1;
            state_d = S_IDLE;
         end else wd_d = wd_q + 24'd1;
`endif
         S_DONE: begin
            fc_d    = fc_q + 16'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pose_q  <= '0;
         fc_q    <= '0;
         dc_q    <= '0;
`ifdef FRAME_SEQ_WATCHDOG_EN
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pose_q  <= pose_d;
         fc_q    <= fc_d;
         dc_q    <= dc_d;
`ifdef FRAME_SEQ_WATCHDOG_EN
         wd_q    <= wd_d;
`endif
      end
   end

   // pulses are masked while reset is asserted so a mid-frame reset emits nothing
   assign mesh_update_mvp = (!reset && state_q == S_UPDATE) ? '1 : '0;
   assign mesh_start      = (!reset && state_q == S_START) ? NUM_MESH'(1) << idx_q : '0;
   assign raster_start    = !reset && state_q == S_RGO;
   assign frame_done      = !reset && state_q == S_DONE;
   assign frame_drop      = !reset && drop;
`ifdef FRAME_SEQ_WATCHDOG_EN
   assign error           = !reset && err_c;
`else
   assign error           = 1'b0;
`endif
   assign busy            = state_q != S_IDLE;
   assign frame_count     = fc_q;
   assign drop_count      = dc_q;
   assign roll            = pose_q[0];
   assign pitch           = pose_q[1];
   assign yaw             = pose_q[2];
   assign x               = pose_q[3];
   assign y               = pose_q[4];
   assign z               = pose_q[5];
endmodule

// File: tb/tb_frame_pipe_sequencer.sv
// tb_frame_pipe_sequencer: directed frames; expected pulses queued by stimulus, checked by a negedge monitor.
module tb_frame_pipe_sequencer;
   localparam int NM = 2;
   logic clock = 1'b0, reset = 1'b1, frame_tick = 1'b0, pose_valid = 1'b0, raster_done = 1'b0;
   logic [31:0] roll_in = '0, pitch_in = '0, yaw_in = '0, x_in = '0, y_in = '0, z_in = '0;
   logic [31:0] roll, pitch, yaw, x, y, z;
   logic [NM-1:0] mesh_update_mvp, mesh_start, mesh_done = '0;
   logic raster_start, busy, frame_done, frame_drop, error;
   logic [15:0] frame_count;
   logic [7:0] drop_count;
   int cyc = 0, vectors = 0, miscompares = 0;
   int exp_fc = 0, exp_dc = 0;
   logic [31:0] exp_roll = '0, exp_x = '0, exp_z = '0;

   typedef struct {int k; int c; logic [31:0] v;} ev_t;
   ev_t sb[$];
   string nm[6] = '{"update_mvp", "mesh_start", "raster_start", "frame_done", "frame_drop", "error"};

   frame_pipe_sequencer #(.NUM_MESH(NM), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .pose_valid(pose_valid),
      .roll_in(roll_in), .pitch_in(pitch_in), .yaw_in(yaw_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .roll(roll), .pitch(pitch), .yaw(yaw), .x(x), .y(y), .z(z),
      .mesh_update_mvp(mesh_update_mvp), .mesh_start(mesh_start), .mesh_done(mesh_done),
      .raster_start(raster_start), .raster_done(raster_done), .busy(busy), .frame_done(frame_done),
      .frame_drop(frame_drop), .error(error), .frame_count(frame_count), .drop_count(drop_count));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int k, input int c, input logic [31:0] v);
      sb.push_back('{k, c, v});
   endtask

   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // monitor: every pulse the DUT presents must match the oldest queued expectation of that kind
   logic [31:0] act [6];
   int f;
   always @(negedge clock) begin
      act[0] = 32'(mesh_update_mvp);
      act[1] = 32'(mesh_start);
      act[2] = 32'(raster_start);
      act[3] = 32'(frame_done);
      act[4] = 32'(frame_drop);
      act[5] = 32'(error);
      for (int k = 0; k < 6; k++) begin
         f = -1;
         for (int i = 0; i < sb.size(); i++)
            if (sb[i].k == k) begin
               f = i;
               break;
            end
         if (act[k] != 0) begin
            vectors++;
            if (f < 0) begin
               miscompares++;
               $display("FAIL %s: unexpected value %0h at cycle %0d", nm[k], act[k], cyc);
            end else begin
               if (sb[f].c != cyc || sb[f].v != act[k]) begin
                  miscompares++;
                  $display("FAIL %s: got %0h at cycle %0d, expected %0h at cycle %0d",
                           nm[k], act[k], cyc, sb[f].v, sb[f].c);
               end
               sb.delete(f);
            end
         end else if (f >= 0 && sb[f].c <= cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: missing %0h expected at cycle %0d", nm[k], sb[f].v, sb[f].c);
            sb.delete(f);
         end
      end
   end

   task automatic check_reset_state();
      check("busy_after_reset", 64'(busy), 64'd0);
      check("frame_count_after_reset", 64'(frame_count), 64'd0);
      check("drop_count_after_reset", 64'(drop_count), 64'd0);
      check("roll_after_reset", 64'(roll), 64'd0);
      check("x_after_reset", 64'(x), 64'd0);
      exp_fc = 0;
      exp_dc = 0;
      exp_roll = '0;
      exp_x = '0;
      exp_z = '0;
   endtask

   task automatic do_frame(input int dly, input bit pv, input logic [31:0] r, input logic [31:0] xx,
                           input int ndrop, input bit abort);
      int t, s, nd;
      t = cyc;
      nd = 0;
      frame_tick = 1'b1;
      pose_valid = pv;
      roll_in = r;
      x_in = xx;
      z_in = r ^ xx;
      pitch_in = 32'd1;
      yaw_in = 32'd2;
      y_in = 32'd3;
      if (pv) begin
         exp_roll = r;
         exp_x = xx;
         exp_z = r ^ xx;
      end
      push(0, t + 1, 32'h3);
      push(1, t + 2, 32'h1);
      step();
      frame_tick = 1'b0;
      pose_valid = 1'b0;
      s = t + 2;
      for (int i = 0; i < NM; i++) begin
         while (cyc < s + dly) begin
            frame_tick = (i == 0 && nd < ndrop);
            if (frame_tick) begin
               push(4, cyc, 32'h1);
               nd++;
               exp_dc = exp_dc < 255 ? exp_dc + 1 : 255;
            end
            step();
         end
         frame_tick = 1'b0;
         mesh_done[i] = 1'b1;
         if (i < NM - 1) push(1, cyc + 1, 32'(1 << (i + 1)));
         else push(2, cyc + 1, 32'h1);
         step();
         mesh_done[i] = 1'b0;
         s = cyc;
      end
      check("roll_mid_frame", 64'(roll), 64'(exp_roll));
      check("x_mid_frame", 64'(x), 64'(exp_x));
      check("z_mid_frame", 64'(z), 64'(exp_z));
      if (abort) begin
         step();
         reset = 1'b1;
         step();
         reset = 1'b0;
         check_reset_state();
      end else begin
         while (cyc < s + dly) step();
         raster_done = 1'b1;
         push(3, cyc + 1, 32'h1);
         step();
         raster_done = 1'b0;
         step();
         exp_fc++;
         check("busy_after_frame", 64'(busy), 64'd0);
         check("frame_count", 64'(frame_count), 64'(exp_fc));
         check("drop_count", 64'(drop_count), 64'(exp_dc));
         check("roll_end_frame", 64'(roll), 64'(exp_roll));
         check("x_end_frame", 64'(x), 64'(exp_x));
      end
   endtask

   initial begin
      int t;
      step();
      step();
      reset = 1'b0;
      step();
      check_reset_state();
      do_frame(3, 1'b1, 32'h3F80_0000, 32'd5, 0, 1'b0);
      do_frame(2, 1'b0, 32'h4000_0000, 32'd99, 0, 1'b0);
      do_frame(10, 1'b1, 32'h1234_5678, 32'd7, 3, 1'b0);
      do_frame(310, 1'b1, 32'hCAFE_0001, 32'd8, 300, 1'b0);
      // pipe 1 done held high while pipe 0 runs must not skip pipe 0
      t = cyc;
      frame_tick = 1'b1;
      mesh_done = 2'b10;
      push(0, t + 1, 32'h3);
      push(1, t + 2, 32'h1);
      step();
      frame_tick = 1'b0;
      while (cyc < t + 5) step();
      mesh_done = 2'b11;
      push(1, t + 6, 32'h2);
      step();
      push(2, t + 8, 32'h1);
      step();
      step();
      mesh_done = 2'b00;
      step();
      raster_done = 1'b1;
      push(3, t + 10, 32'h1);
      step();
      raster_done = 1'b0;
      step();
      exp_fc++;
      check("busy_after_hold", 64'(busy), 64'd0);
      check("frame_count_after_hold", 64'(frame_count), 64'(exp_fc));
      // stalled pipe 0
      t = cyc;
      frame_tick = 1'b1;
      push(0, t + 1, 32'h3);
      push(1, t + 2, 32'h1);
      step();
      frame_tick = 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
      push(5, t + 19, 32'h1);
      while (cyc < t + 20) step();
      check("busy_after_timeout", 64'(busy), 64'd0);
      check("frame_count_after_timeout", 64'(frame_count), 64'(exp_fc));
`else
      while (cyc < t + 40) step();
      check("busy_while_stalled", 64'(busy), 64'd1);
      check("frame_count_while_stalled", 64'(frame_count), 64'(exp_fc));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_state();
`endif
      do_frame(3, 1'b1, 32'hDEAD_BEEF, 32'd11, 0, 1'b1);
      do_frame(3, 1'b1, 32'h0BAD_F00D, 32'd12, 0, 1'b0);
      step();
      step();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
